// File: rtl/mux_rr_arbiter.sv
// mux_rr_arbiter: round-robin arbiter driving the select of an 8:1 bit mux, with a registered out/valid.
// Optional ARB_HOLD_LIMIT_EN: preempt an owner after MAX_HOLD granted cycles while others are waiting.
module mux_rr_arbiter #(
    parameter int MAX_HOLD = 4,
    parameter int HOLD_W   = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] req,
    input  logic [7:0] in,
    output logic [7:0] gnt,
    output logic [2:0] sel,
    output logic       out,
    output logic       valid
);

    typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

    state_t     state, state_nxt;
    logic [2:0] ptr, ptr_nxt, sel_nxt, winner;
    logic [7:0] gnt_nxt;
    logic       take_new;

    if (MAX_HOLD < 1 || MAX_HOLD > 15 || (2 ** HOLD_W) <= MAX_HOLD) begin : g_bad_params
        $error("mux_rr_arbiter: MAX_HOLD must be 1..15 and fit in HOLD_W bits");
    end

`ifdef ARB_HOLD_LIMIT_EN
    logic [HOLD_W-1:0] hold_cnt, hold_nxt, hold_inc;
    logic [7:0]        others;
    logic              limit_hit;
`endif

    // First requester at or after p, wrapping 7->0; rotate so p lands on bit 0, then encode.
    function automatic logic [2:0] rr_pick(input logic [7:0] r, input logic [2:0] p);
        logic [15:0] dbl;
        logic [7:0]  rot;
        logic [2:0]  idx;
        dbl = {r, r} >> p;
        rot = dbl[7:0];
        idx = '0;
        for (int i = 7; i >= 0; i--) begin
            if (rot[i]) idx = 3'(i);
        end
        return idx + p;
    endfunction

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path can infer a latch.
        state_nxt = state;
        ptr_nxt   = ptr;
        gnt_nxt   = gnt;
        sel_nxt   = sel;
        take_new  = 1'b0;
        winner    = rr_pick(req, ptr);
`ifdef ARB_HOLD_LIMIT_EN
        others    = req & ~gnt;
        hold_nxt  = hold_cnt;
        hold_inc  = (hold_cnt == HOLD_W'(MAX_HOLD)) ? hold_cnt : hold_cnt + HOLD_W'(1);
        limit_hit = (hold_inc == HOLD_W'(MAX_HOLD));
`endif
        case (state)
            IDLE: begin
                if (|req) take_new = 1'b1;
            end
            GRANT: begin
                if (!req[sel]) begin
                    if (|req) begin
                        take_new = 1'b1;
                    end else begin
                        state_nxt = IDLE;
                        gnt_nxt   = '0;
                    end
                end
`ifdef ARB_HOLD_LIMIT_EN
                // ptr already sits past the owner, so the owner is searched last.
                else if (limit_hit && |others) begin
                    take_new = 1'b1;
                end else begin
                    hold_nxt = hold_inc;
                end
`endif
            end
            default: state_nxt = IDLE;
        endcase

        if (take_new) begin
            state_nxt = GRANT;
            sel_nxt   = winner;
            gnt_nxt   = 8'b1 << winner;
            ptr_nxt   = winner + 3'd1;
`ifdef ARB_HOLD_LIMIT_EN
            hold_nxt  = '0;
`endif
        end
    end

    // NOTE: registers use non-blocking assignments so every update sees pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            ptr   <= '0;
            gnt   <= '0;
            sel   <= '0;
            out   <= 1'b0;
            valid <= 1'b0;
        end else begin
            state <= state_nxt;
            ptr   <= ptr_nxt;
            gnt   <= gnt_nxt;
            sel   <= sel_nxt;
            out   <= (state == GRANT) ? in[sel] : 1'b0;
            valid <= (state == GRANT);
        end
    end

`ifdef ARB_HOLD_LIMIT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) hold_cnt <= '0;
        else     hold_cnt <= hold_nxt;
    end
`endif

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// tb_mux_rr_arbiter: directed and randomized checks of mux_rr_arbiter against a cycle-level
// reference model of the round-robin rules (owner index, pointer, granted-cycle count).
module tb_mux_rr_arbiter;

    localparam int MAX_HOLD = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] req = '0;
    logic [7:0] in  = '0;
    logic [7:0] gnt;
    logic [2:0] sel;
    logic       out;
    logic       valid;

    int checks   = 0;
    int failures = 0;

    // Reference model: owner index (-1 when idle), priority pointer, cycles held.
    int   m_owner;
    int   m_ptr;
    int   m_sel;
    int   m_cnt;
    logic m_out;
    logic m_valid;
    int   order[$];

    mux_rr_arbiter #(.MAX_HOLD(MAX_HOLD), .HOLD_W(4)) dut (
        .clk   (clk),
        .rst   (rst),
        .req   (req),
        .in    (in),
        .gnt   (gnt),
        .sel   (sel),
        .out   (out),
        .valid (valid)
    );

    always #5 clk = ~clk;

    function automatic int find_first(input logic [7:0] r, input int p);
        for (int k = 0; k < 8; k++) begin
            if (r[(p + k) % 8]) return (p + k) % 8;
        end
        return -1;
    endfunction

    function automatic logic [12:0] exp_vec();
        logic [7:0] g;
        g = (m_owner >= 0) ? (8'b1 << m_owner) : 8'h00;
        return {g, 3'(m_sel), m_out, m_valid};
    endfunction

    task automatic model_reset();
        m_owner = -1;
        m_ptr   = 0;
        m_sel   = 0;
        m_cnt   = 0;
        m_out   = 1'b0;
        m_valid = 1'b0;
    endtask

    task automatic model_grant(input int w);
        order.push_back(w);
        m_owner = w;
        m_sel   = w;
        m_ptr   = (w + 1) % 8;
        m_cnt   = 0;
    endtask

    task automatic model_edge(input logic [7:0] r, input logic [7:0] d);
        logic [7:0] oth;
        m_out   = (m_owner >= 0) ? d[m_sel] : 1'b0;
        m_valid = (m_owner >= 0);
        if (m_owner < 0) begin
            if (r != 8'h00) model_grant(find_first(r, m_ptr));
        end else if (!r[m_owner]) begin
            if (r != 8'h00) model_grant(find_first(r, m_ptr));
            else            m_owner = -1;
        end else begin
            m_cnt++;
            oth = r & ~(8'b1 << m_owner);
`ifdef ARB_HOLD_LIMIT_EN
            if (m_cnt >= MAX_HOLD && oth != 8'h00) model_grant(find_first(oth, m_ptr));
`endif
        end
    endtask

    // One clock edge: the model consumes the inputs seen at the edge; outputs sampled 1 ns later.
    task automatic tick();
        @(posedge clk);
        model_edge(req, in);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req = '0;
        #3;
        model_reset();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req = '0;
        in  = 8'($urandom);
        #2;
        checks++;
        if ({gnt, sel, out, valid} !== 13'h0) begin
            failures++;
            $display("FAIL reset_assert got=%h exp=%h", {gnt, sel, out, valid}, 13'h0);
        end
        #2;
        model_reset();
        rst = 1'b0;
        for (int n = 0; n < 10; n++) begin
            in = 8'($urandom);
            tick();
            checks++;
            if ({gnt, sel, out, valid} !== 13'h0) begin
                failures++;
                $display("FAIL reset_idle cyc%0d got=%h exp=%h", n, {gnt, sel, out, valid}, 13'h0);
            end
        end
    endtask

    task automatic test_single();
        do_reset();
        req = 8'h10;
        in  = 8'h10;
        tick();
        checks++;
        if (gnt !== 8'h10 || sel !== 3'd4) begin
            failures++;
            $display("FAIL single_grant gnt=%h sel=%0d exp gnt=10 sel=4", gnt, sel);
        end
        tick();
        checks++;
        if (out !== 1'b1 || valid !== 1'b1) begin
            failures++;
            $display("FAIL single_data out=%b valid=%b exp out=1 valid=1", out, valid);
        end
        req = 8'h00;
        tick();
        checks++;
        if (gnt !== 8'h00 || valid !== 1'b1 || sel !== 3'd4) begin
            failures++;
            $display("FAIL single_drop gnt=%h valid=%b sel=%0d exp gnt=00 valid=1 sel=4", gnt, valid, sel);
        end
        tick();
        checks++;
        if ({gnt, sel, out, valid} !== exp_vec() || valid !== 1'b0) begin
            failures++;
            $display("FAIL single_idle got=%h exp=%h", {gnt, sel, out, valid}, exp_vec());
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        req = 8'h81;
        in  = 8'h80;
        tick();
        checks++;
        if (gnt !== 8'h01 || sel !== 3'd0) begin
            failures++;
            $display("FAIL b2b_first gnt=%h sel=%0d exp gnt=01 sel=0", gnt, sel);
        end
        req = 8'h80;
        tick();
        checks++;
        if (gnt !== 8'h80 || sel !== 3'd7) begin
            failures++;
            $display("FAIL b2b_switch gnt=%h sel=%0d exp gnt=80 sel=7", gnt, sel);
        end
        req = 8'h00;
        tick();
        checks++;
        if ({gnt, sel, out, valid} !== exp_vec() || gnt !== 8'h00 || sel !== 3'd7) begin
            failures++;
            $display("FAIL b2b_idle got=%h exp=%h", {gnt, sel, out, valid}, exp_vec());
        end
    endtask

    task automatic test_fairness();
        int prev_owner;
        int own_cycles;
        do_reset();
        order.delete();
        prev_owner = -1;
        own_cycles = 0;
        req = 8'hFF;
        for (int n = 0; n < 18; n++) begin
            in = 8'($urandom);
            tick();
            checks++;
            if ({gnt, sel, out, valid} !== exp_vec()) begin
                failures++;
                $display("FAIL fair_cyc%0d got=%h exp=%h", n, {gnt, sel, out, valid}, exp_vec());
            end
            own_cycles = (m_owner == prev_owner) ? own_cycles + 1 : 1;
            prev_owner = m_owner;
            req = (own_cycles == 2 && m_owner >= 0) ? ~(8'b1 << m_owner) : 8'hFF;
        end
        checks++;
        if (order.size() < 9) begin
            failures++;
            $display("FAIL fair_count grants=%0d exp>=9", order.size());
        end else begin
            for (int k = 0; k < 9; k++) begin
                checks++;
                if (order[k] !== k % 8) begin
                    failures++;
                    $display("FAIL fair_order idx%0d got=%0d exp=%0d", k, order[k], k % 8);
                end
            end
        end
    endtask

    task automatic test_hold_limit();
        logic [7:0] exp5;
        logic [7:0] exp9;
`ifdef ARB_HOLD_LIMIT_EN
        exp5 = 8'h02;
        exp9 = 8'h01;
`else
        exp5 = 8'h01;
        exp9 = 8'h01;
`endif
        do_reset();
        req = 8'h03;
        for (int n = 1; n <= 20; n++) begin
            in = 8'($urandom);
            tick();
            checks++;
            if ({gnt, sel, out, valid} !== exp_vec()) begin
                failures++;
                $display("FAIL hold_cyc%0d got=%h exp=%h", n, {gnt, sel, out, valid}, exp_vec());
            end
            if (n == 4 || n == 5 || n == 9) begin
                checks++;
                if (gnt !== ((n == 4) ? 8'h01 : (n == 5) ? exp5 : exp9)) begin
                    failures++;
                    $display("FAIL hold_edge%0d gnt=%h exp=%h", n, gnt,
                             (n == 4) ? 8'h01 : (n == 5) ? exp5 : exp9);
                end
            end
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        req = 8'h20;
        in  = 8'h20;
        tick();
        tick();
        checks++;
        if (gnt !== 8'h20 || valid !== 1'b1) begin
            failures++;
            $display("FAIL arst_setup gnt=%h valid=%b exp gnt=20 valid=1", gnt, valid);
        end
        #1;
        rst = 1'b1;
        #1;
        checks++;
        if ({gnt, out, valid} !== 10'h0) begin
            failures++;
            $display("FAIL arst_midcycle gnt=%h out=%b valid=%b exp all 0", gnt, out, valid);
        end
        model_reset();
        #1;
        rst = 1'b0;
        req = 8'h21;
        tick();
        checks++;
        if (gnt !== 8'h01 || sel !== 3'd0) begin
            failures++;
            $display("FAIL arst_restart gnt=%h sel=%0d exp gnt=01 sel=0", gnt, sel);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 3) == 0) req = 8'($urandom);
            in = 8'($urandom);
            tick();
            checks++;
            if ({gnt, sel, out, valid} !== exp_vec()) begin
                failures++;
                $display("FAIL rand_cyc%0d req=%h got=%h exp=%h", n, req, {gnt, sel, out, valid}, exp_vec());
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_single();
        test_back_to_back();
        test_fairness();
        test_hold_limit();
        test_async_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
